// File: rtl/pipe_add_nb_if.sv
// pipe_add_nb_if: operand/result handshake bundle for pipe_add_nb.
// The sub select exists only when ADD_SUB_EN is defined.
interface pipe_add_nb_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef ADD_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

`ifdef ADD_SUB_EN
    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );
    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
`else
    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );
    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
`endif
endinterface

// File: rtl/pipe_add_nb.sv
// pipe_add_nb: pipelined ripple adder, one CHUNK-bit slice per stage, valid/ready flow control.
// Define ADD_SUB_EN to enable the pipelined subtract select (a + ~b + (c_in ^ 1)).
module pipe_add_nb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_add_nb_if.slave bus
);
    localparam int unsigned STAGES = WIDTH / CHUNK;

    logic              adv;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cy_q,  cy_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              ovf_q, ovf_d;
`ifdef ADD_SUB_EN
    logic [STAGES-1:0] sub_q, sub_d;
    logic [STAGES-1:0] src_sub;
`endif

    // Stage-k operands: index 0 comes from the bus, index k>0 from register k-1.
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];

    logic [WIDTH-1:0]  b_eff;
    logic [CHUNK-1:0]  a_sl;
    logic [CHUNK-1:0]  b_sl;
    logic [CHUNK:0]    slice;

    // Whole pipeline moves in lockstep; a held result freezes every stage.
    assign adv = !vld_q[STAGES-1] || bus.out_ready;

    always_comb begin : stage_src
        src_v[0] = bus.in_valid;
        src_a[0] = bus.a;
        src_b[0] = bus.b;
        src_s[0] = '0;
`ifdef ADD_SUB_EN
        src_sub[0] = bus.sub;
        src_c[0]   = bus.c_in ^ bus.sub;
`else
        src_c[0]   = bus.c_in;
`endif
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_v[k] = vld_q[k-1];
            src_c[k] = cy_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
`ifdef ADD_SUB_EN
            src_sub[k] = sub_q[k-1];
`endif
        end
    end

    always_comb begin : stage_add
        b_eff = '0;
        a_sl  = '0;
        b_sl  = '0;
        slice = '0;
        ovf_d = 1'b0;
        for (int unsigned k = 0; k < STAGES; k++) begin
`ifdef ADD_SUB_EN
            b_eff    = src_b[k] ^ {WIDTH{src_sub[k]}};
            sub_d[k] = src_sub[k];
`else
            b_eff    = src_b[k];
`endif
            a_sl  = src_a[k][k*CHUNK +: CHUNK];
            b_sl  = b_eff[k*CHUNK +: CHUNK];
            slice = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, src_c[k]};

            vld_d[k] = src_v[k];
            a_d[k]   = src_a[k];
            b_d[k]   = src_b[k];
            s_d[k]   = src_s[k];
            s_d[k][k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
            cy_d[k]  = slice[CHUNK];

            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            if (k == STAGES - 1) begin
                ovf_d = slice[CHUNK] ^ (slice[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cy_q  <= '0;
            ovf_q <= 1'b0;
`ifdef ADD_SUB_EN
            sub_q <= '0;
`endif
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            ovf_q <= ovf_d;
`ifdef ADD_SUB_EN
            sub_q <= sub_d;
`endif
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.sum       = s_q[STAGES-1];
    assign bus.c_out     = cy_q[STAGES-1];
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_add_nb.sv
// tb_pipe_add_nb: randomized and directed checks of pipe_add_nb against a whole-word arithmetic model.
// Build with ADD_SUB_EN defined to also cover subtraction.
module tb_pipe_add_nb;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CHUNK  = 8;
    localparam int unsigned STAGES = WIDTH / CHUNK;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;

    pipe_add_nb_if #(.WIDTH(WIDTH)) bus ();

    pipe_add_nb #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    res_t        exp_q[$];

    logic             cur_xfer, cur_ov, cur_ir, cur_c, cur_o;
    logic [WIDTH-1:0] cur_sum;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic ci, input logic sb);
        logic [WIDTH-1:0] bo;
        logic [WIDTH:0]   full;
        res_t             r;
        bo     = sb ? ~bv : bv;
        full   = {1'b0, av} + {1'b0, bo} + {{WIDTH{1'b0}}, ci ^ sb};
        r.s    = full[WIDTH-1:0];
        r.c    = full[WIDTH];
        r.o    = (av[WIDTH-1] == bo[WIDTH-1]) && (full[WIDTH-1] != av[WIDTH-1]);
        return r;
    endfunction

    // Starts at a falling edge, evaluates 1 time unit later, ends at the next falling edge.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic ci, input logic sb, input logic ordy, output logic acc);
        res_t e;
        logic sbe;
`ifdef ADD_SUB_EN
        sbe     = sb;
        bus.sub = sb;
`else
        sbe     = 1'b0 & sb;
`endif
        bus.in_valid  = v;
        bus.a         = av;
        bus.b         = bv;
        bus.c_in      = ci;
        bus.out_ready = ordy;
        #1;
        cur_ov   = bus.out_valid;
        cur_ir   = bus.in_ready;
        cur_sum  = bus.sum;
        cur_c    = bus.c_out;
        cur_o    = bus.ovf;
        cur_xfer = bus.out_valid && ordy;
        acc      = v && bus.in_ready;
        if (cur_xfer) begin
            if (exp_q.size() == 0) begin
                check_eq("out_valid_unexpected", cur_ov, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check_eq("sum", cur_sum, e.s);
                check_eq("c_out", cur_c, e.c);
                check_eq("ovf", cur_o, e.o);
            end
        end
        if (acc) exp_q.push_back(model(av, bv, ci, sbe));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic one_beat(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                            input logic ci, input logic sb,
                            input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        logic        acc;
        int unsigned n;
        cycle(1'b1, av, bv, ci, sb, 1'b1, acc);
        check_eq({tag, "_accept"}, acc, 1'b1);
        n = 0;
        do begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            n++;
        end while (!cur_xfer && n < 12);
        check_eq({tag, "_seen"}, cur_xfer, 1'b1);
        check_eq({tag, "_latency"}, n, STAGES);
        check_eq({tag, "_sum"}, cur_sum, es);
        check_eq({tag, "_c_out"}, cur_c, ec);
        check_eq({tag, "_ovf"}, cur_o, eo);
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic        acc;
        int unsigned i, got, stall, n;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
        bus.out_ready = 1'b1;
`ifdef ADD_SUB_EN
        bus.sub       = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("reset_out_valid", bus.out_valid, 1'b0);
        check_eq("reset_sum", bus.sum, '0);
        check_eq("reset_c_out", bus.c_out, 1'b0);
        check_eq("reset_ovf", bus.ovf, 1'b0);
        check_eq("reset_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);

        one_beat("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        one_beat("sovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        one_beat("cin", 32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
`ifdef ADD_SUB_EN
        one_beat("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        one_beat("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        one_beat("sub_borrow", 32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
`endif

        // Six-beat stream; out_ready drops for 3 cycles right after the first result.
        i = 0; got = 0; stall = 0; n = 0;
        while (got < 6 && n < 60) begin
            cycle(i < 6, i, 32'h10, 1'b0, 1'b0, stall == 0, acc);
            if (stall > 0) begin
                check_eq("stall_in_ready", cur_ir, 1'b0);
                check_eq("stall_out_valid", cur_ov, 1'b1);
                check_eq("stall_sum", cur_sum, 32'h10 + got);
                stall--;
            end
            if (acc) i++;
            if (cur_xfer) begin
                check_eq("stream_order", cur_sum, 32'h10 + got);
                got++;
                if (got == 1) stall = 3;
            end
            n++;
        end
        check_eq("stream_count", got, 6);
        check_eq("stream_accepted", i, 6);

        // Two beats in flight, then reset: neither may ever emerge.
        cycle(1'b1, 32'h1111, 32'h2222, 1'b0, 1'b0, 1'b1, acc);
        cycle(1'b1, 32'h3333, 32'h4444, 1'b0, 1'b0, 1'b1, acc);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_eq("midrst_out_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            check_eq("midrst_flush", cur_ov, 1'b0);
        end

        // Random traffic with random back-pressure.
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 9) < 7, pick(), pick(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, acc);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            n++;
        end
        check_eq("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
